// File: rtl/logic_unit_pkg.sv
// Shared opcode and FSM-state definitions for the arbitrated logic unit.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/nbit_logic_unit.sv
// Purely combinational N-bit bitwise logic unit (AND/OR/XOR/NOR).
module nbit_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters,
// with a single registered result slot and saturating per-requester accept counters.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t         state;
    logic           last_grant;
    logic           can_accept;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [1:0]     sel_op;
    logic [N-1:0]   lu_y;

    // Grant: lone requester wins; on contention the one not granted last wins.
    always_comb begin
        can_accept = (state == ST_EMPTY) || rsp_ready;
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = !rst && can_accept && grant0;
        req1_ready = !rst && can_accept && grant1;
        accept     = req0_ready || req1_ready;
        sel_a      = grant1 ? req1_a  : req0_a;
        sel_b      = grant1 ? req1_b  : req0_b;
        sel_op     = grant1 ? req1_op : req0_op;
    end

    nbit_logic_unit #(.N(N)) u_lu (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (lu_y)
    );

    assign rsp_valid = (state == ST_FULL);

    // Result slot FSM, priority pointer and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cnt0       <= '0;
            cnt1       <= '0;
        end else if (accept) begin
            state      <= ST_FULL;
            rsp_data   <= lu_y;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
            if (req0_ready && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
            if (req1_ready && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
        end else if ((state == ST_FULL) && rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (CNT_W=2 to reach saturation).
module tb_logic_unit_arbiter;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_op, req1_op;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0]     rsp_data;
    logic [CNT_W-1:0] cnt0, cnt1;

    int vectors;
    int miscompares;

    logic [31:0] op_exp [4];
    logic [31:0] sat_exp [5];
    logic [31:0] sat_cnt [5];

    logic_unit_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        op_exp  = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'h0000_AAAA};
        sat_exp = '{32'h0000_00FE, 32'h0000_00FD, 32'h0000_00FC, 32'h0000_00FB, 32'h0000_00FA};
        sat_cnt = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;

        // Reset: two cycles, ready must stay low even with requesters valid.
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  rsp_data,       32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_cnt0",  32'(cnt0),      32'd0);
        chk("rst_cnt1",  32'(cnt1),      32'd0);

        // Single OR op from requester 0.
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F; req0_op = 2'b01;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data",  rsp_data,       32'h0000_00FF);
        chk("single_id",    32'(rsp_id),    32'd0);
        chk("single_cnt0",  32'(cnt0),      32'd1);

        // Fresh reset, then contention rotation 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_a = 32'hAAAA_5555; req0_b = 32'hFFFF_0000; req0_op = 2'b00;
        req1_a = 32'hAAAA_5555; req1_b = 32'hFFFF_0000; req1_op = 2'b10;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            chk($sformatf("rot%0d_ready0", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rot%0d_ready1", i), 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rot%0d_id", i),   32'(rsp_id), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rot%0d_data", i), rsp_data,
                (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_0000);
        end
        req0_valid = 1'b0;
        chk("rot_cnt0", 32'(cnt0), 32'd2);
        chk("rot_cnt1", 32'(cnt1), 32'd2);

        // Backpressure: slot holds req1 XOR result while req1 waits.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req1_a = 32'hDEAD_0000 + 32'(i);
            #1;
            chk($sformatf("bp%0d_ready1", i), 32'(req1_ready), 32'd0);
            chk($sformatf("bp%0d_ready0", i), 32'(req0_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_data", i),  rsp_data,       32'h5555_5555);
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
        end
        req1_a = 32'hAAAA_5555;
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("bp_data", rsp_data,    32'hFFFF_5555);
        chk("bp_id",   32'(rsp_id), 32'd1);
        chk("bp_cnt1", 32'(cnt1),   32'd3);
        tick();
        chk("bp_drain_valid", 32'(rsp_valid), 32'd0);

        // All four opcodes through requester 0.
        req0_a = 32'hAAAA_5555; req0_b = 32'hFFFF_0000;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_op = 2'(k);
            #1;
            chk($sformatf("op%0d_ready0", k), 32'(req0_ready), 32'd1);
            tick();
            chk($sformatf("op%0d_data", k), rsp_data, op_exp[k]);
        end

        // Reset mid-operation with both requesters valid.
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        req1_valid = 1'b1; rst = 1'b1;
        #1;
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        chk("midrst_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cnt0",  32'(cnt0),      32'd0);
        chk("midrst_cnt1",  32'(cnt1),      32'd0);
        rst = 1'b0;
        #1;
        chk("postrst_ready0", 32'(req0_ready), 32'd1);
        chk("postrst_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("postrst_id", 32'(rsp_id), 32'd0);

        // Counter saturation: five req0 accepts from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_b = 32'h0000_00FF; req0_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req0_a = 32'(i + 1);
            #1;
            chk($sformatf("sat%0d_ready0", i), 32'(req0_ready), 32'd1);
            tick();
            chk($sformatf("sat%0d_cnt0", i),  32'(cnt0),      sat_cnt[i]);
            chk($sformatf("sat%0d_data", i),  rsp_data,       sat_exp[i]);
            chk($sformatf("sat%0d_valid", i), 32'(rsp_valid), 32'd1);
        end
        req0_valid = 1'b0;
        tick();
        chk("sat_drain_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
